// File: rtl/bicubic_bmp_reader_pkg.sv
// Shared constants and the padded-to-source coordinate clamp for the
// bicubic BMP reader.
package bicubic_bmp_reader_pkg;

  localparam int unsigned PIX_W      = 24;
  localparam int unsigned PAD_LEFT   = 1;
  localparam int unsigned PAD_RIGHT  = 2;
  localparam int unsigned PAD_TOP    = 1;
  localparam int unsigned PAD_BOTTOM = 2;
  localparam int unsigned CNT_W      = 10;

  // Map a padded coordinate onto the source range [0, n-1] (edge replication).
  function automatic logic [CNT_W-1:0] pad_clamp(input logic [CNT_W-1:0] c,
                                                 input int unsigned      pad,
                                                 input int unsigned      n);
    int unsigned v;
    v = 32'(c);
    if (v < pad) return '0;
    if (v - pad >= n) return CNT_W'(n - 1);
    return CNT_W'(v - pad);
  endfunction

endpackage

// File: rtl/bicubic_bmp_reader_dff.sv
// Flop primitives.
//   dffl  : load-enable register, no reset.        ports: clk, en, d, q
//   dfflr : load-enable register, async active-low
//           reset to zero.                         ports: clk, rst_n, en, d, q
module dffl #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (en) q <= d;
  end
endmodule

module dfflr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/bicubic_bmp_reader_rom.sv
// Stored source image with combinational read.
//   addr  : word address (row-major, top row first)
//   rdata : pixel at addr
module bmp_pixel_rom #(
  parameter int unsigned DEPTH     = 66,
  parameter int unsigned DW        = 24,
  parameter int unsigned AW        = 7,
  parameter string       INIT_FILE = "image.hex"
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];
endmodule

// File: rtl/bicubic_bmp_reader.sv
// Border-padded RGB888 pixel source for the bicubic upscaler window buffer.
// Streams (WIDTH+3)*(HEIGHT+3) pixels in raster order, one per valid/ready
// handshake, replicating 1 column/row left/top and 2 right/bottom.
//   clk, rst_n : clock, async active-low reset
//   ready      : consumer accepts current pixel
//   valid      : data holds a padded-frame pixel
//   data       : current pixel {R,G,B}
// Build option BMP_READER_LOOP_EN: repeat frames forever instead of stopping.
module bicubic_bmp_reader
  import bicubic_bmp_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 11,
  parameter int unsigned HEIGHT    = 6,
  parameter int unsigned DW        = PIX_W,
  parameter string       INIT_FILE = "image.hex"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);
  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AFW   = 2 * CNT_W;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WIDTH + PAD_LEFT + PAD_RIGHT - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(HEIGHT + PAD_TOP + PAD_BOTTOM - 1);

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d, sx, sy;
  logic             cnt_en, data_en, flag_en, hs;
  logic             valid_q, valid_d, done_q, done_d;
  logic [AFW-1:0]   addr_full;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    rom_data, data_q;

  assign hs = valid_q & ready;

  // Next coordinate and load enables; the ROM is addressed by the next coordinate.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_en  = 1'b0;
    data_en = 1'b0;
    flag_en = 1'b0;
    if (!valid_q && !done_q) begin
      // first cycle out of reset: present (0,0)
      valid_d = 1'b1;
      flag_en = 1'b1;
      data_en = 1'b1;
    end else if (hs) begin
      if (col_q != COL_LAST) begin
        col_d   = col_q + CNT_W'(1);
        cnt_en  = 1'b1;
        data_en = 1'b1;
      end else if (row_q != ROW_LAST) begin
        col_d   = '0;
        row_d   = row_q + CNT_W'(1);
        cnt_en  = 1'b1;
        data_en = 1'b1;
      end else begin
`ifdef BMP_READER_LOOP_EN
        col_d   = '0;
        row_d   = '0;
        cnt_en  = 1'b1;
        data_en = 1'b1;
`else
        valid_d = 1'b0;
        done_d  = 1'b1;
        flag_en = 1'b1;
`endif
      end
    end
  end

  assign sx        = pad_clamp(col_d, PAD_LEFT, WIDTH);
  assign sy        = pad_clamp(row_d, PAD_TOP, HEIGHT);
  assign addr_full = AFW'(sy) * AFW'(WIDTH) + AFW'(sx);
  assign addr      = AW'(addr_full);

  bmp_pixel_rom #(
    .DEPTH(DEPTH), .DW(DW), .AW(AW), .INIT_FILE(INIT_FILE)
  ) u_rom (
    .addr(addr), .rdata(rom_data)
  );

  dfflr #(.W(CNT_W)) u_col   (.clk(clk), .rst_n(rst_n), .en(cnt_en),  .d(col_d),   .q(col_q));
  dfflr #(.W(CNT_W)) u_row   (.clk(clk), .rst_n(rst_n), .en(cnt_en),  .d(row_d),   .q(row_q));
  dfflr #(.W(1))     u_valid (.clk(clk), .rst_n(rst_n), .en(flag_en), .d(valid_d), .q(valid_q));
  dfflr #(.W(1))     u_done  (.clk(clk), .rst_n(rst_n), .en(flag_en), .d(done_d),  .q(done_q));
  dffl  #(.W(DW))    u_data  (.clk(clk), .en(data_en), .d(rom_data), .q(data_q));

  // The data flop has no reset; hide its content until a pixel has been loaded.
  assign valid = valid_q;
  assign data  = (valid_q | done_q) ? data_q : '0;

endmodule

// File: tb/tb_bicubic_bmp_reader.sv
// Scoreboard bench for bicubic_bmp_reader: a padded-frame reference model
// pushes expected pixels, a monitor pops them on every handshake.
module tb_bicubic_bmp_reader;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int PW   = W + 3;
  localparam int PH   = H + 3;
`ifdef BMP_READER_LOOP_EN
  localparam int FR   = 2;
  localparam bit LOOP = 1'b1;
`else
  localparam int FR   = 1;
  localparam bit LOOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, ready, rst2_n, ready2;
  logic        valid, valid2;
  logic [23:0] data, data2;

  always #5 clk = ~clk;

  bicubic_bmp_reader #(.WIDTH(W), .HEIGHT(H), .DW(24), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .valid(valid), .data(data));

  bicubic_bmp_reader #(.WIDTH(1), .HEIGHT(1), .DW(24), .INIT_FILE("")) dut1 (
    .clk(clk), .rst_n(rst2_n), .ready(ready2), .valid(valid2), .data(data2));

  int          n_vec = 0;
  int          n_err = 0;
  int          hs_count = 0;
  int          ready_mode = 0;
  logic [23:0] img [W*H];
  logic [23:0] expq [$];
  logic [23:0] exp1q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: padded (r,c) reads the nearest source pixel.
  function automatic logic [23:0] model_pix(int r, int c);
    return img[clampi(r - 1, 0, H - 1) * W + clampi(c - 1, 0, W - 1)];
  endfunction

  task automatic push_frame();
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++)
        expq.push_back(model_pix(r, c));
  endtask

  task automatic load_img(input bit rnd);
    for (int i = 0; i < W*H; i++) begin
      img[i] = rnd ? 24'($urandom) : {8'h00, 8'(i / W), 8'(i % W)};
      dut.u_rom.mem[i] = img[i];
    end
  endtask

  // Ready generator, gated so no handshake is offered beyond the expected stream.
  initial begin
    bit tog, g;
    ready = 1'b0; ready2 = 1'b0; tog = 1'b0;
    forever begin
      @(posedge clk); #1;
      tog = ~tog;
      case (ready_mode)
        0:       g = 1'b1;
        1:       g = tog;
        default: g = 1'($urandom_range(0, 1));
      endcase
      ready  = g && (expq.size() > 0);
      ready2 = exp1q.size() > 0;
    end
  end

  // Monitor: compare on handshakes, check that stalls hold data/valid.
  initial begin
    bit          stall;
    logic [23:0] sdata, e;
    stall = 1'b0; sdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 32'(valid), 32'd1);
          chk("stall_data", 32'(data), 32'(sdata));
        end
        if (valid && ready) begin
          if (expq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL extra_pixel: got %h expected none at %0t", data, $time);
          end else begin
            e = expq.pop_front();
            chk("pixel", 32'(data), 32'(e));
            hs_count++;
          end
        end
        stall = valid && !ready;
        sdata = data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst2_n && valid2 && ready2) begin
        if (exp1q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_pixel_1x1: got %h expected none at %0t", data2, $time);
        end else begin
          chk("pixel_1x1", 32'(data2), 32'(exp1q.pop_front()));
        end
      end
    end
  end

  task automatic start_frames(input int frames);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    @(negedge clk);
    expq.delete();
    hs_count = 0;
    for (int f = 0; f < frames; f++) push_frame();
    rst_n = 1'b1;
    #1;
    chk("valid_before_edge", 32'(valid), 32'd0);
    @(negedge clk); #1;
    chk("valid_latency", 32'(valid), 32'd1);
    chk("first_pixel", 32'(data), 32'(model_pix(0, 0)));
  endtask

  task automatic finish_frames();
    int n = 0;
    while (expq.size() > 0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (expq.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
      expq.delete();
    end
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_valid", 32'(valid), LOOP ? 32'd1 : 32'd0);
      chk("post_data", 32'(data), LOOP ? 32'(model_pix(0, 0)) : 32'(model_pix(PH - 1, PW - 1)));
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rst2_n = 1'b0;
    load_img(1'b0);
    dut1.u_rom.mem[0] = 24'hABCDEF;

    // coordinate-pattern image, ready held high
    ready_mode = 0;
    start_frames(FR);
    finish_frames();

    // 1010 backpressure
    ready_mode = 1;
    start_frames(FR);
    finish_frames();

    // random images with random backpressure
    repeat (2) begin
      load_img(1'b1);
      ready_mode = 2;
      start_frames(FR);
      finish_frames();
    end

    // reset after 10 pixels, then a full restart
    load_img(1'b0);
    ready_mode = 0;
    start_frames(1);
    n = 0;
    while (hs_count < 10 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_reset_reached", 32'(hs_count >= 10), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(valid), 32'd0);
    chk("mid_reset_data", 32'(data), 32'd0);
    start_frames(FR);
    finish_frames();

    // 1x1 image: 16 replicated pixels
    for (int i = 0; i < 16; i++) exp1q.push_back(24'hABCDEF);
    @(negedge clk);
    rst2_n = 1'b1;
    n = 0;
    while (exp1q.size() > 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp1q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout_1x1: got %0d pending expected 0", exp1q.size());
    end
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_valid_1x1", 32'(valid2), LOOP ? 32'd1 : 32'd0);
      chk("post_data_1x1", 32'(data2), 32'hABCDEF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
